// File: rtl/dm_pkg.sv
//==============================================================================
// dm_pkg -- shared types and defaults for the data-memory access controller
// Revision: 1.0
//==============================================================================
`default_nettype none

package dm_pkg;

  localparam int C_ADDR_W = 8;
  localparam int C_DATA_W = 8;
  localparam int C_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RSP  = 2'd3
  } dm_state_t;

endpackage

`default_nettype wire

// File: rtl/dm_access_ctrl.sv
//==============================================================================
// dm_access_ctrl -- single-outstanding load/store sequencer for Data_memory
// Revision: 1.0
//==============================================================================
`default_nettype none

module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W = C_ADDR_W,
  parameter int DATA_W = C_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [C_CNT_W-1:0] ld_cnt,
  output logic [C_CNT_W-1:0] st_cnt
);

  dm_state_t           r_state;
  dm_state_t           w_state_nxt;
  logic                w_req_ready;
  logic                w_rsp_valid;
  logic                w_dm_we;
  logic                w_accept;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rsp_data;
  logic [C_CNT_W-1:0]  r_ld_cnt;
  logic [C_CNT_W-1:0]  r_st_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // dm_we/rsp_valid decode straight from the state register, so an async
  // reset pulls them low in the same cycle it is asserted.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_dm_we     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_req_ready = rst_n;
        if (req_valid && rst_n) begin
          w_state_nxt = req_we ? ST_WR : ST_RD;
        end
      end
      ST_WR: begin
        w_dm_we     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      ST_RD: begin
        w_state_nxt = ST_RSP;
      end
      ST_RSP: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_accept = req_valid & w_req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
      r_ld_cnt   <= '0;
      r_st_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      // Memory read data is valid by the end of the RD cycle.
      if (r_state == ST_RD) begin
        r_rsp_data <= dm_rdata;
      end
      if (r_state == ST_WR) begin
        r_st_cnt <= r_st_cnt + 8'd1;
      end
      if ((r_state == ST_RSP) && rsp_ready) begin
        r_ld_cnt <= r_ld_cnt + 8'd1;
      end
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = w_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign dm_addr   = r_addr;
  assign dm_wdata  = r_wdata;
  assign dm_we     = w_dm_we;
  assign ld_cnt    = r_ld_cnt;
  assign st_cnt    = r_st_cnt;

endmodule

`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
//==============================================================================
// tb_dm_access_ctrl -- directed bench with a behavioural Data_memory model
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_dm_access_ctrl;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [7:0] dm_addr;
  logic [7:0] dm_wdata;
  logic       dm_we;
  logic [7:0] dm_rdata;
  logic [7:0] ld_cnt;
  logic [7:0] st_cnt;

  int n_checks;
  int n_errors;

  logic [7:0] mem [256];

  dm_access_ctrl u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_we     (dm_we),
    .dm_rdata  (dm_rdata),
    .ld_cnt    (ld_cnt),
    .st_cnt    (st_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data_memory: synchronous write, read data valid within the cycle
  always @(posedge clk) begin
    if (dm_we) mem[dm_addr] <= dm_wdata;
  end
  assign dm_rdata = mem[dm_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_dm_we", {31'd0, dm_we}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    check("rst_dm_addr", {24'd0, dm_addr}, 32'd0);
    check("rst_dm_wdata", {24'd0, dm_wdata}, 32'd0);
    check("rst_ld_cnt", {24'd0, ld_cnt}, 32'd0);
    check("rst_st_cnt", {24'd0, st_cnt}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_rel_ready", {31'd0, req_ready}, 32'd1);
  endtask

  // Returns at the negedge inside WR so a following request can go back-to-back.
  task automatic do_store(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
    check("st_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_addr = 8'hC3; req_wdata = 8'h3C;
    check("st_we", {31'd0, dm_we}, 32'd1);
    check("st_addr", {24'd0, dm_addr}, {24'd0, a});
    check("st_wdata", {24'd0, dm_wdata}, {24'd0, d});
  endtask

  task automatic do_load(input logic [7:0] a, input logic [7:0] exp, input int stall);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 8'hEE;
    check("ld_ready", {31'd0, req_ready}, 32'd1);
    check("ld_idle_we", {31'd0, dm_we}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    check("ld_rd_we", {31'd0, dm_we}, 32'd0);
    check("ld_rd_valid", {31'd0, rsp_valid}, 32'd0);
    check("ld_rd_ready", {31'd0, req_ready}, 32'd0);
    check("ld_rd_addr", {24'd0, dm_addr}, {24'd0, a});
    @(negedge clk);
    check("ld_valid", {31'd0, rsp_valid}, 32'd1);
    check("ld_data", {24'd0, rsp_data}, {24'd0, exp});
    for (int i = 0; i < stall; i++) begin
      // A competing store is presented while busy and must be ignored.
      req_valid = 1'b1; req_we = 1'b1; req_addr = a ^ 8'hFF; req_wdata = 8'h55;
      rsp_ready = 1'b0;
      @(negedge clk);
      check("stall_valid", {31'd0, rsp_valid}, 32'd1);
      check("stall_data", {24'd0, rsp_data}, {24'd0, exp});
      check("stall_ready", {31'd0, req_ready}, 32'd0);
      check("stall_addr", {24'd0, dm_addr}, {24'd0, a});
      check("stall_we", {31'd0, dm_we}, 32'd0);
    end
    req_valid = 1'b0; req_we = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("ld_done_valid", {31'd0, rsp_valid}, 32'd0);
    check("ld_done_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = 8'd0; req_wdata = 8'd0; rsp_ready = 1'b0;

    do_reset();

    // Single store, then address/data hold in IDLE
    do_store(8'd81, 8'd2);
    @(negedge clk);
    check("idle_we", {31'd0, dm_we}, 32'd0);
    check("idle_addr_hold", {24'd0, dm_addr}, 32'd81);
    check("idle_wdata_hold", {24'd0, dm_wdata}, 32'd2);
    check("st_cnt_1", {24'd0, st_cnt}, 32'd1);
    check("mem81", {24'd0, mem[81]}, 32'd2);

    // Two loads of distinct addresses
    do_store(8'd31, 8'd5);
    do_load(8'd81, 8'd2, 0);
    do_load(8'd31, 8'd5, 0);
    check("ld_cnt_2", {24'd0, ld_cnt}, 32'd2);
    check("st_cnt_2", {24'd0, st_cnt}, 32'd2);

    // Back-pressured load
    do_load(8'd81, 8'd2, 5);
    check("ld_cnt_3", {24'd0, ld_cnt}, 32'd3);
    check("st_cnt_after_stall", {24'd0, st_cnt}, 32'd2);

    // Store then load same address back-to-back
    do_store(8'd40, 8'h33);
    do_store(8'd7, 8'hAA);
    do_load(8'd7, 8'hAA, 0);
    check("ld_cnt_4", {24'd0, ld_cnt}, 32'd4);
    check("st_cnt_4", {24'd0, st_cnt}, 32'd4);

    // Reset asserted in the middle of WR
    do_reset();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd40; req_wdata = 8'h11;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    check("midwr_we_pre", {31'd0, dm_we}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midwr_we_drop", {31'd0, dm_we}, 32'd0);
    check("midwr_st_cnt", {24'd0, st_cnt}, 32'd0);
    @(negedge clk);
    check("midwr_mem_kept", {24'd0, mem[40]}, 32'h33);
    check("midwr_st_cnt_after", {24'd0, st_cnt}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("midwr_ready", {31'd0, req_ready}, 32'd1);

    // Reset asserted while a response is pending
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd81;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("midrsp_valid_pre", {31'd0, rsp_valid}, 32'd1);
    check("midrsp_data_pre", {24'd0, rsp_data}, 32'd2);
    rst_n = 1'b0;
    #1;
    check("midrsp_valid_drop", {31'd0, rsp_valid}, 32'd0);
    check("midrsp_data_clr", {24'd0, rsp_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrsp_no_rsp", {31'd0, rsp_valid}, 32'd0);
    check("midrsp_ld_cnt", {24'd0, ld_cnt}, 32'd0);

    // Store counter wrap
    for (int i = 0; i < 255; i++) begin
      do_store(i[7:0], i[7:0] ^ 8'h5A);
    end
    @(negedge clk);
    check("st_cnt_255", {24'd0, st_cnt}, 32'd255);
    do_store(8'd255, 8'hA5);
    @(negedge clk);
    check("st_cnt_wrap", {24'd0, st_cnt}, 32'd0);
    do_load(8'd200, 8'd200 ^ 8'h5A, 0);
    check("ld_cnt_final", {24'd0, ld_cnt}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dm_access_ctrl.md
DM_ACCESS_CTRL -- requirements
Module: dm_access_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, data-memory address width.
REQ-002 Parameter DATA_W, default 8, data-memory word width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  pipeline presents a load/store request.
REQ-006 req_ready  output  1  controller can accept a request this cycle.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  ADDR_W  target address.
REQ-009 req_wdata  input  DATA_W  store data; ignored for loads.
REQ-010 rsp_valid  output  1  load result available.
REQ-011 rsp_ready  input  1  pipeline accepts the load result.
REQ-012 rsp_data  output  DATA_W  load result.
REQ-013 dm_addr  output  ADDR_W  to Data_memory address input (Iea2).
REQ-014 dm_wdata  output  DATA_W  to Data_memory write-data input (IRa).
REQ-015 dm_we  output  1  to Data_memory write control (DMCR); 1 = write.
REQ-016 dm_rdata  input  DATA_W  from Data_memory read output (ODM).
REQ-017 ld_cnt, st_cnt  output  8 each  completed load / store counts.

Function
REQ-018 The FSM SHALL have states IDLE, WR, RD, RSP; at most one request is outstanding.
REQ-019 req_ready SHALL be 1 only in IDLE.
REQ-020 In IDLE, a handshake (req_valid & req_ready) SHALL latch req_addr, req_wdata and req_we, then go to WR if req_we=1, else RD.
REQ-021 In WR, dm_we SHALL be 1 for exactly one cycle with the latched dm_addr/dm_wdata; next state IDLE; st_cnt increments; no response is generated.
REQ-022 In RD, dm_we SHALL be 0 and dm_addr held; Data_memory read latency is one cycle, so dm_rdata SHALL be captured into rsp_data at the end of the RD cycle; next state RSP.
REQ-023 In RSP, rsp_valid SHALL be 1 and rsp_data held stable until rsp_ready=1; on that edge go to IDLE and ld_cnt increments.
REQ-024 dm_we SHALL be 0 in every state other than WR.
REQ-025 dm_addr/dm_wdata SHALL hold their last latched values in IDLE (no glitching to the request bus).
REQ-026 Throughput: a store occupies 2 cycles (IDLE, WR); a load occupies at least 3 cycles (IDLE, RD, RSP).
REQ-027 A load issued immediately after a store to the same address SHALL return the stored value (in-order, single outstanding).
REQ-028 ld_cnt and st_cnt SHALL wrap 255 -> 0 without flag.
REQ-029 req_valid while not in IDLE SHALL be ignored; the request remains pending upstream.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE, dm_we=0, rsp_valid=0, rsp_data=0, dm_addr=0, dm_wdata=0, ld_cnt=0, st_cnt=0; req_ready becomes 1 after release.
REQ-031 Reset in WR SHALL deassert dm_we immediately; the store is dropped. Reset in RD/RSP SHALL discard the load with no response.

Structure
REQ-032 State encoding (IDLE/WR/RD/RSP) and ADDR_W/DATA_W defaults SHALL live in a shared package dm_pkg.
REQ-033 A single flat module; no sub-module, Data_memory is instantiated only in the bench.

Verification
REQ-034 Reset, then store addr 81 data 2 -> dm_we=1 for one cycle with dm_addr=81, dm_wdata=2; st_cnt=1.
REQ-035 Store addr 31 data 5, then load addr 81 -> rsp_valid with rsp_data=2; load 31 -> rsp_data=5; ld_cnt=2.
REQ-036 Load with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stable, req_ready=0 throughout.
REQ-037 Store 0xAA to addr 7, load addr 7 back-to-back -> rsp_data=0xAA.
REQ-038 Assert rst_n=0 mid-WR -> dm_we drops in the same cycle, st_cnt stays 0; 256 stores -> st_cnt wraps to 0.
